// File: rtl/axis_golden_checker.sv
// AXI-Stream sink that compares each 128-bit beat against a golden block read
// from a 1-cycle-latency BRAM port and reports match/mismatch/framing results.
module axis_golden_checker #(
  parameter int unsigned IMAGE_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned SKIP_BEATS  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [127:0]          s_axis_tdata,
  input  logic [15:0]           s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] gold_bram_addr,
  output logic                  gold_bram_en,
  input  logic [127:0]          gold_bram_dout,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   match_count,
  output logic [ADDR_WIDTH:0]   mismatch_count,
  output logic [ADDR_WIDTH-1:0] first_mismatch_idx,
  output logic                  first_mismatch_valid,
  output logic                  tlast_error,
  output logic                  pass
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned NBYTES = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        beat_idx_q;
  logic [CW-1:0]        match_q, mismatch_q;
  logic [ADDR_WIDTH-1:0] first_idx_q;
  logic                 first_valid_q;
  logic                 tlast_err_q;

  logic                 hs;
  logic                 is_last_idx;
  logic                 terminate;
  logic                 start_ok;
  logic                 in_window;
  logic                 beat_ok;
  logic                 en_c;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign hs          = (state_q == S_CMP) && s_axis_tvalid;
  assign is_last_idx = (beat_idx_q == CW'(IMAGE_DEPTH - 1));
  assign terminate   = hs && (is_last_idx || s_axis_tlast);
  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Leading beats below SKIP_BEATS are consumed but not compared
  generate
    if (SKIP_BEATS == 0) begin : g_no_skip
      assign in_window = 1'b1;
    end else begin : g_skip
      assign in_window = (beat_idx_q >= CW'(SKIP_BEATS));
    end
  endgenerate

  // Byte-masked comparison of the current beat against the golden block
  always_comb begin
    beat_ok = 1'b1;
    for (int i = 0; i < NBYTES; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != gold_bram_dout[8*i +: 8])) begin
        beat_ok = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and golden read request; reads run one beat ahead of the stream
  always_comb begin
    state_d = state_q;
    en_c    = 1'b0;
    addr_c  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          en_c    = 1'b1;
          addr_c  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        if (hs) begin
          if (terminate) begin
            state_d = S_DONE;
          end else begin
            en_c   = 1'b1;
            addr_c = ADDR_WIDTH'(beat_idx_q + CW'(1));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Beat index, counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx_q    <= '0;
      match_q       <= '0;
      mismatch_q    <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      tlast_err_q   <= 1'b0;
    end else if (start_ok) begin
      beat_idx_q    <= '0;
      match_q       <= '0;
      mismatch_q    <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      tlast_err_q   <= 1'b0;
    end else if (hs) begin
      beat_idx_q <= beat_idx_q + CW'(1);
      if (in_window) begin
        if (beat_ok) begin
          if (match_q < CW'(IMAGE_DEPTH)) begin
            match_q <= match_q + CW'(1);
          end
        end else begin
          if (mismatch_q < CW'(IMAGE_DEPTH)) begin
            mismatch_q <= mismatch_q + CW'(1);
          end
          if (!first_valid_q) begin
            first_idx_q   <= ADDR_WIDTH'(beat_idx_q);
            first_valid_q <= 1'b1;
          end
        end
      end
      if (is_last_idx != s_axis_tlast) begin
        tlast_err_q <= 1'b1;
      end
    end
  end

  assign s_axis_tready        = (state_q == S_CMP);
  assign done                 = (state_q == S_DONE);
  assign gold_bram_en         = rst_n && en_c;
  assign gold_bram_addr       = rst_n ? addr_c : '0;
  assign match_count          = match_q;
  assign mismatch_count       = mismatch_q;
  assign first_mismatch_idx   = first_idx_q;
  assign first_mismatch_valid = first_valid_q;
  assign tlast_error          = tlast_err_q;
  assign pass                 = done && (mismatch_q == '0) && !tlast_err_q;

endmodule

// File: tb/tb_axis_golden_checker.sv
// Bench for axis_golden_checker: two instances (no skip / one skipped beat)
// share one stream; a transaction-level model predicts results every cycle.
module tb_axis_golden_checker;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [127:0]  tdata = '0;
  logic [15:0]   tkeep = '0;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;

  logic          tready0, en0, done0, fmv0, te0, pass0;
  logic [AW-1:0] addr0, fmi0;
  logic [CW-1:0] mc0, mm0;
  logic [127:0]  dout0 = '0;

  logic          tready1, en1, done1, fmv1, te1, pass1;
  logic [AW-1:0] addr1, fmi1;
  logic [CW-1:0] mc1, mm1;
  logic [127:0]  dout1 = '0;

  logic [127:0]  gold  [DEPTH];
  logic [127:0]  bdata [DEPTH];
  logic [15:0]   bkeep [DEPTH];
  bit            blast [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_golden_checker #(.IMAGE_DEPTH(DEPTH), .ADDR_WIDTH(AW), .SKIP_BEATS(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready0),
    .gold_bram_addr(addr0), .gold_bram_en(en0), .gold_bram_dout(dout0),
    .done(done0), .match_count(mc0), .mismatch_count(mm0),
    .first_mismatch_idx(fmi0), .first_mismatch_valid(fmv0),
    .tlast_error(te0), .pass(pass0));

  axis_golden_checker #(.IMAGE_DEPTH(DEPTH), .ADDR_WIDTH(AW), .SKIP_BEATS(1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready1),
    .gold_bram_addr(addr1), .gold_bram_en(en1), .gold_bram_dout(dout1),
    .done(done1), .match_count(mc1), .mismatch_count(mm1),
    .first_mismatch_idx(fmi1), .first_mismatch_valid(fmv1),
    .tlast_error(te1), .pass(pass1));

  // Golden BRAMs: dout only updates on an enabled read
  always @(posedge clk) if (en0) dout0 <= gold[addr0];
  always @(posedge clk) if (en1) dout1 <= gold[addr1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit masked_eq(input logic [127:0] a, input logic [127:0] b,
                                   input logic [15:0] k);
    for (int i = 0; i < 16; i++)
      if (k[i] && (a[8*i +: 8] != b[8*i +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- model ----------------
  // phase: 0 idle, 1 waiting for first golden block, 2 accepting, 3 finished
  int m_phase = 0;
  int m_cnt   = 0;
  int m_match [2];
  int m_mism  [2];
  int m_fidx  [2];
  bit m_fval  [2];
  bit m_terr  = 0;

  bit           p_rst = 0, p_start = 0, p_hs = 0;
  logic [127:0] p_data;
  logic [15:0]  p_keep;
  bit           p_last;

  int ncyc = 0, start_cyc = 0, tready_cyc = -1, done_cyc = -1, en_pulses = 0;

  function automatic void model_clear();
    m_cnt = 0;
    m_terr = 0;
    for (int s = 0; s < 2; s++) begin
      m_match[s] = 0; m_mism[s] = 0; m_fidx[s] = 0; m_fval[s] = 0;
    end
  endfunction

  function automatic void model_beat(input logic [127:0] d, input logic [15:0] k, input bit l);
    logic [127:0] g;
    g = gold[m_cnt];
    for (int s = 0; s < 2; s++) begin
      if (m_cnt >= s) begin
        if (masked_eq(d, g, k)) m_match[s]++;
        else begin
          m_mism[s]++;
          if (!m_fval[s]) begin m_fidx[s] = m_cnt; m_fval[s] = 1; end
        end
      end
    end
    if (m_cnt == DEPTH - 1) begin
      if (!l) m_terr = 1;
      m_phase = 3;
    end else if (l) begin
      m_terr = 1;
      m_phase = 3;
    end
    m_cnt++;
  endfunction

  // Per-cycle compare: apply what the last edge did, then check all outputs
  always @(negedge clk) begin
    bit exp_en;
    ncyc++;
    if (p_rst) begin model_clear(); m_phase = 0; end
    else if (p_start) begin model_clear(); m_phase = 1; end
    else if (m_phase == 1) m_phase = 2;
    else if (p_hs) model_beat(p_data, p_keep, p_last);

    chk("tready",   tready0, (m_phase == 2));
    chk("tready_s", tready1, (m_phase == 2));
    chk("done",     done0,   (m_phase == 3));
    chk("done_s",   done1,   (m_phase == 3));
    chk("match",    mc0, m_match[0]);
    chk("match_s",  mc1, m_match[1]);
    chk("mism",     mm0, m_mism[0]);
    chk("mism_s",   mm1, m_mism[1]);
    chk("fval",     fmv0, m_fval[0]);
    chk("fval_s",   fmv1, m_fval[1]);
    if (m_fval[0]) chk("fidx",   fmi0, m_fidx[0]);
    if (m_fval[1]) chk("fidx_s", fmi1, m_fidx[1]);
    chk("tlast_err",   te0, m_terr);
    chk("tlast_err_s", te1, m_terr);
    chk("pass",   pass0, (m_phase == 3) && m_mism[0] == 0 && !m_terr);
    chk("pass_s", pass1, (m_phase == 3) && m_mism[1] == 0 && !m_terr);

    exp_en = rst_n && ((start && (m_phase == 0 || m_phase == 3)) ||
                       (m_phase == 2 && tvalid && !tlast && m_cnt < DEPTH - 1));
    chk("bram_en",   en0, exp_en);
    chk("bram_en_s", en1, exp_en);
    if (exp_en) begin
      chk("bram_addr",   addr0, (m_phase == 2) ? m_cnt + 1 : 0);
      chk("bram_addr_s", addr1, (m_phase == 2) ? m_cnt + 1 : 0);
    end

    p_rst   = !rst_n;
    p_start = rst_n && start && (m_phase == 0 || m_phase == 3);
    p_hs    = rst_n && tvalid && (m_phase == 2);
    p_data  = tdata;
    p_keep  = tkeep;
    p_last  = tlast;

    if (p_start) begin
      start_cyc = ncyc; tready_cyc = -1; done_cyc = -1; en_pulses = 0;
    end
    if (en0) en_pulses++;
    if (tready0 && tready_cyc < 0) tready_cyc = ncyc - start_cyc;
    if (done0 && done_cyc < 0) done_cyc = ncyc - start_cyc;
  end

  // ---------------- stimulus ----------------
  task automatic set_clean();
    for (int i = 0; i < DEPTH; i++) begin
      bdata[i] = gold[i];
      bkeep[i] = 16'hFFFF;
      blast[i] = (i == DEPTH - 1);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Send n beats (gap_pct % idle cycles); rst_at >= 0 resets after that many beats
  task automatic run(input int n, input int gap_pct, input int rst_at);
    int idx = 0;
    int guard = 0;
    bit hs;
    pulse_start();
    while (idx < n && guard < 1000) begin
      if (idx == rst_at) begin
        tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_tready", tready0, 0);
        chk("rst_done",   done0, 0);
        chk("rst_match",  mc0, 0);
        chk("rst_mism",   mm0, 0);
        chk("rst_en",     en0, 0);
        chk("rst_pass",   pass0, 0);
        rst_n = 1'b1;
        break;
      end
      tvalid = ($urandom_range(99) >= gap_pct);
      tdata  = bdata[idx];
      tkeep  = bkeep[idx];
      tlast  = blast[idx];
      @(negedge clk);
      hs = tvalid && tready0;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    chk("stream_timeout", guard < 1000, 1);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) gold[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_tready", tready0, 0);
    chk("reset_done",   done0, 0);
    chk("reset_match",  mc0, 0);
    chk("reset_fval",   fmv0, 0);
    chk("reset_pass",   pass0, 0);

    // clean run
    set_clean();
    run(DEPTH, 0, -1);
    chk("clean_tready_cycle", tready_cyc, 2);
    chk("clean_done_cycle",   done_cyc, 66);
    chk("clean_match",        mc0, 64);
    chk("clean_mism",         mm0, 0);
    chk("clean_pass",         pass0, 1);
    chk("clean_en_pulses",    en_pulses, 64);

    // corruption in beats 5 and 40
    set_clean();
    bdata[5][0]   = ~bdata[5][0];
    bdata[40][77] = ~bdata[40][77];
    run(DEPTH, 0, -1);
    chk("corrupt_mism",  mm0, 2);
    chk("corrupt_match", mc0, 62);
    chk("corrupt_fidx",  fmi0, 5);
    chk("corrupt_fval",  fmv0, 1);
    chk("corrupt_pass",  pass0, 0);

    // masked upper half wrong on beat 7
    set_clean();
    bdata[7] = {~gold[7][127:64], gold[7][63:0]};
    bkeep[7] = 16'h00FF;
    run(DEPTH, 0, -1);
    chk("mask_match", mc0, 64);
    chk("mask_pass",  pass0, 1);

    // backpressure
    set_clean();
    run(DEPTH, 50, -1);
    chk("bp_match",     mc0, 64);
    chk("bp_pass",      pass0, 1);
    chk("bp_en_pulses", en_pulses, 64);

    // early tlast on beat 10
    set_clean();
    blast[10] = 1'b1;
    run(11, 0, -1);
    chk("early_done",  done0, 1);
    chk("early_terr",  te0, 1);
    chk("early_match", mc0, 11);

    // missing tlast on the final beat
    set_clean();
    blast[63] = 1'b0;
    run(DEPTH, 0, -1);
    chk("miss_terr", te0, 1);
    chk("miss_pass", pass0, 0);

    // garbage beat 0: skipped by dut_skip, mismatches in dut
    set_clean();
    bdata[0] = ~gold[0];
    run(DEPTH, 0, -1);
    chk("skip_match_s", mc1, 63);
    chk("skip_pass_s",  pass1, 1);
    chk("skip_mism",    mm0, 1);

    // reset mid-run after 30 beats, then a clean run
    set_clean();
    run(DEPTH, 20, 30);
    chk("abort_done", done0, 0);
    run(DEPTH, 0, -1);
    chk("after_rst_match", mc0, 64);
    chk("after_rst_pass",  pass0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
